// File: rtl/disp_scan_mux.sv
// disp_scan_mux: display scan multiplexer.
// Selects one of CHANNELS packed data channels and drives it to a registered output,
// with a matching active-low one-hot channel enable. The channel either follows `sel`
// (manual) or auto-advances every DIV cycles (auto scan).
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst_n    - synchronous active-low reset
//   data_in  - packed channels; channel k is data_in[k*WIDTH +: WIDTH]
//   mode     - 0 = manual select, 1 = auto scan
//   sel      - manual channel index
//   en       - scan enable; 0 freezes prescaler and channel in auto mode
//   blank    - per-channel blank mask; 1 forces that channel's output to zero
//   o        - registered selected data
//   an       - registered one-hot active-low channel enable
//   ch       - current channel index register
//   wrap     - one-cycle pulse coincident with the auto scan returning to channel 0
module disp_scan_mux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV      = 16,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       blank,
  output logic [WIDTH-1:0]          o,
  output logic [CHANNELS-1:0]       an,
  output logic [SEL_W-1:0]          ch,
  output logic                      wrap
);

  localparam int unsigned PCNT_W = $clog2(DIV);

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic                mode_q;
  logic                wrap_q, wrap_d;
  logic [WIDTH-1:0]    o_q, o_d;
  logic [CHANNELS-1:0] an_q, an_d;

  // Prescaler / channel next state.
  always_comb begin
    pcnt_d = pcnt_q;
    ch_d   = ch_q;
    wrap_d = 1'b0;
    if (mode != mode_q) begin
      // Mode transition: restart the dwell, keep the channel so the scan resumes from it.
      pcnt_d = '0;
    end else if (!mode) begin
      pcnt_d = '0;
      // Out-of-range indices (non-power-of-two CHANNELS) leave the channel untouched.
      if (32'(sel) < CHANNELS) begin
        ch_d = sel;
      end
    end else if (en) begin
      if (pcnt_q == PCNT_W'(DIV - 1)) begin
        pcnt_d = '0;
        if (ch_q == SEL_W'(CHANNELS - 1)) begin
          ch_d   = '0;
          wrap_d = 1'b1;
        end else begin
          ch_d = ch_q + SEL_W'(1);
        end
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
    end
  end

  // Output selection from the current channel register (one cycle of latency).
  always_comb begin
    o_d  = '0;
    an_d = '1;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch_q == SEL_W'(k)) begin
        an_d[k] = 1'b0;
        if (!blank[k]) begin
          o_d = data_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      ch_q   <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
      o_q    <= '0;
      an_q   <= '1;
    end else begin
      pcnt_q <= pcnt_d;
      ch_q   <= ch_d;
      mode_q <= mode;
      wrap_q <= wrap_d;
      o_q    <= o_d;
      an_q   <= an_d;
    end
  end

  assign o    = o_q;
  assign an   = an_q;
  assign ch   = ch_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
module tb_disp_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        mode;
  logic [1:0]  sel;
  logic        en;
  logic [3:0]  blank;
  logic [3:0]  o;
  logic [3:0]  an;
  logic [1:0]  ch;
  logic        wrap;

  // Three-channel instance, used only for the out-of-range select case.
  logic [11:0] data_in3;
  logic [1:0]  sel3;
  logic [2:0]  blank3;
  logic [3:0]  o3;
  logic [2:0]  an3;
  logic [1:0]  ch3;
  logic        wrap3;

  int n_cmp;
  int n_fail;

  disp_scan_mux #(.WIDTH(4), .CHANNELS(4), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .sel(sel), .en(en),
    .blank(blank), .o(o), .an(an), .ch(ch), .wrap(wrap)
  );

  disp_scan_mux #(.WIDTH(4), .CHANNELS(3), .DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in3), .mode(1'b0), .sel(sel3), .en(1'b1),
    .blank(blank3), .o(o3), .an(an3), .ch(ch3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; en = 1'b0; blank = 4'b0000;
    data_in = 16'hD3A5; sel3 = 2'd0; blank3 = 3'b000; data_in3 = 12'h3A5;
    tick(2);
    n_cmp++; if (o !== 4'h0) begin n_fail++; $display("FAIL reset_o: got %h want 0", o); end
    n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_cmp++; if (ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", ch); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if (o !== 4'h5) begin n_fail++; $display("FAIL post_reset_o: got %h want 5", o); end
    n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL post_reset_an: got %b want 1110", an); end
  endtask

  task automatic test_manual;
    sel = 2'd2;
    tick(1);
    n_cmp++; if (ch !== 2'd2) begin n_fail++; $display("FAIL man_ch2: got %0d want 2", ch); end
    n_cmp++; if (o !== 4'h5) begin n_fail++; $display("FAIL man_o_lat: got %h want 5", o); end
    tick(1);
    n_cmp++; if (o !== 4'h3) begin n_fail++; $display("FAIL man_o2: got %h want 3", o); end
    n_cmp++; if (an !== 4'b1011) begin n_fail++; $display("FAIL man_an2: got %b want 1011", an); end
    sel = 2'd3;
    tick(2);
    n_cmp++; if (o !== 4'hD) begin n_fail++; $display("FAIL man_o3: got %h want d", o); end
    n_cmp++; if (an !== 4'b0111) begin n_fail++; $display("FAIL man_an3: got %b want 0111", an); end
    // Three-channel instance: select 2, then illegal 3 must hold 2.
    sel3 = 2'd2;
    tick(2);
    n_cmp++; if (ch3 !== 2'd2) begin n_fail++; $display("FAIL man3_ch2: got %0d want 2", ch3); end
    sel3 = 2'd3;
    tick(2);
    n_cmp++; if (ch3 !== 2'd2) begin n_fail++; $display("FAIL man3_hold: got %0d want 2", ch3); end
    n_cmp++; if (o3 !== 4'h3) begin n_fail++; $display("FAIL man3_o: got %h want 3", o3); end
    n_cmp++; if (an3 !== 3'b011) begin n_fail++; $display("FAIL man3_an: got %b want 011", an3); end
  endtask

  task automatic test_auto;
    logic [1:0] exp_ch;
    logic [1:0] prev_ch;
    logic [3:0] exp_an;
    logic       exp_wrap;
    sel = 2'd0;
    tick(1);
    n_cmp++; if (ch !== 2'd0) begin n_fail++; $display("FAIL auto_start_ch: got %0d want 0", ch); end
    mode = 1'b1; en = 1'b1;
    tick(1);  // mode-change edge: ch held, pcnt cleared
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick(1);
      exp_ch   = 2'((k / 4) % 4);
      exp_wrap = (k == 16);
      n_cmp++;
      if (ch !== exp_ch) begin
        n_fail++; $display("FAIL auto_ch k=%0d: got %0d want %0d", k, ch, exp_ch);
      end
      n_cmp++;
      if (wrap !== exp_wrap) begin
        n_fail++; $display("FAIL auto_wrap k=%0d: got %b want %b", k, wrap, exp_wrap);
      end
      if (k > 0) begin
        prev_ch = 2'(((k - 1) / 4) % 4);
        exp_an  = ~(4'b0001 << prev_ch);
        n_cmp++;
        if (an !== exp_an) begin
          n_fail++; $display("FAIL auto_an k=%0d: got %b want %b", k, an, exp_an);
        end
      end
    end
  endtask

  // Entry state: ch=1, pcnt=0.
  task automatic test_freeze_blank;
    tick(1);
    n_cmp++; if (dut.pcnt_q !== 2'd1) begin n_fail++; $display("FAIL frz_pre_pcnt: got %0d want 1", dut.pcnt_q); end
    en = 1'b0; blank = 4'b0010;
    tick(10);
    n_cmp++; if (ch !== 2'd1) begin n_fail++; $display("FAIL frz_ch: got %0d want 1", ch); end
    n_cmp++; if (dut.pcnt_q !== 2'd1) begin n_fail++; $display("FAIL frz_pcnt: got %0d want 1", dut.pcnt_q); end
    n_cmp++; if (o !== 4'h0) begin n_fail++; $display("FAIL blank_o: got %h want 0", o); end
    n_cmp++; if (an !== 4'b1101) begin n_fail++; $display("FAIL blank_an: got %b want 1101", an); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL frz_wrap: got %b want 0", wrap); end
    blank = 4'b0000; en = 1'b1;
    tick(1);
    n_cmp++; if (o !== 4'hA) begin n_fail++; $display("FAIL unblank_o: got %h want a", o); end
    n_cmp++; if (dut.pcnt_q !== 2'd2) begin n_fail++; $display("FAIL resume_pcnt: got %0d want 2", dut.pcnt_q); end
    tick(1);
    n_cmp++; if (ch !== 2'd1) begin n_fail++; $display("FAIL resume_ch1: got %0d want 1", ch); end
    tick(1);
    n_cmp++; if (ch !== 2'd2) begin n_fail++; $display("FAIL resume_ch2: got %0d want 2", ch); end
  endtask

  // Entry state: ch=2, pcnt=0, mode=1.
  task automatic test_mode_switch_reset;
    tick(1);
    mode = 1'b0; sel = 2'd0;
    tick(1);
    n_cmp++; if (ch !== 2'd2) begin n_fail++; $display("FAIL sw0_ch: got %0d want 2", ch); end
    n_cmp++; if (dut.pcnt_q !== 2'd0) begin n_fail++; $display("FAIL sw0_pcnt: got %0d want 0", dut.pcnt_q); end
    mode = 1'b1;
    tick(1);
    n_cmp++; if (ch !== 2'd2) begin n_fail++; $display("FAIL sw1_ch: got %0d want 2", ch); end
    n_cmp++; if (dut.pcnt_q !== 2'd0) begin n_fail++; $display("FAIL sw1_pcnt: got %0d want 0", dut.pcnt_q); end
    tick(3);
    n_cmp++; if (ch !== 2'd2) begin n_fail++; $display("FAIL sw_dwell_ch: got %0d want 2", ch); end
    tick(1);
    n_cmp++; if (ch !== 2'd3) begin n_fail++; $display("FAIL sw_adv_ch: got %0d want 3", ch); end
    tick(2);
    n_cmp++; if (dut.pcnt_q !== 2'd2) begin n_fail++; $display("FAIL pre_rst_pcnt: got %0d want 2", dut.pcnt_q); end
    rst_n = 1'b0;
    tick(1);
    n_cmp++; if (o !== 4'h0) begin n_fail++; $display("FAIL rst_mid_o: got %h want 0", o); end
    n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL rst_mid_an: got %b want 1111", an); end
    n_cmp++; if (ch !== 2'd0) begin n_fail++; $display("FAIL rst_mid_ch: got %0d want 0", ch); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wrap: got %b want 0", wrap); end
    n_cmp++; if (dut.pcnt_q !== 2'd0) begin n_fail++; $display("FAIL rst_mid_pcnt: got %0d want 0", dut.pcnt_q); end
    rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick(1);
      n_cmp++;
      if (wrap !== 1'b0) begin n_fail++; $display("FAIL post_rst_wrap k=%0d: got %b want 0", k, wrap); end
      n_cmp++;
      if (ch !== ((k == 4) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL post_rst_ch k=%0d: got %0d want %0d", k, ch, (k == 4) ? 1 : 0);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_manual();
    test_auto();
    test_freeze_blank();
    test_mode_switch_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
